// File: rtl/branch_prediction_unit.sv
// Direct-mapped BTB with 2-bit counters and a Fetch->Decode->Execute shadow pipeline.
// Define BPU_JAL_ALLOC_EN to allocate JAL entries and enable uncond_branch_hit_EXE_o.
module branch_prediction_unit #(
    parameter int ENTRY_NUM = 32,
    parameter int XLEN      = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_pipe_i,
    input  logic            stall_fd_i,
    input  logic            flush2fet_i,
    input  logic            flush2dec_i,
    input  logic [XLEN-1:0] pc_IF_i,
    output logic            branch_hit_o,
    output logic            branch_decision_o,
    output logic [XLEN-1:0] branch_target_addr_o,
    input  logic            is_cond_branch_EXE_i,
    input  logic            is_jal_EXE_i,
    input  logic [XLEN-1:0] pc_EXE_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_addr_EXE_i,
    output logic            cond_branch_hit_EXE_o,
    output logic            uncond_branch_hit_EXE_o,
    output logic            cond_branch_misprediction_o
);
    localparam int IDX = $clog2(ENTRY_NUM);
    localparam int TW  = XLEN - IDX - 2;

    typedef struct packed {
        logic            hit;
        logic            decision;
        logic            is_cond;
        logic [XLEN-1:0] target;
    } shadow_t;

    logic [ENTRY_NUM-1:0]           valid;
    logic [ENTRY_NUM-1:0][TW-1:0]   tag;
    logic [ENTRY_NUM-1:0][XLEN-1:0] target;
    logic [ENTRY_NUM-1:0][1:0]      cnt;
`ifdef BPU_JAL_ALLOC_EN
    logic [ENTRY_NUM-1:0]           is_cond;
`endif

    logic [IDX-1:0] rd_idx, wr_idx;
    logic [TW-1:0]  wr_tag;
    logic           rd_cond;
    shadow_t        fd, de;
    logic           unused_bits;

    assign rd_idx = pc_IF_i[IDX+1:2];
    assign wr_idx = pc_EXE_i[IDX+1:2];
    assign wr_tag = pc_EXE_i[XLEN-1:IDX+2];
    assign unused_bits = ^{pc_IF_i[1:0], pc_EXE_i[1:0], is_jal_EXE_i};

`ifdef BPU_JAL_ALLOC_EN
    assign rd_cond = is_cond[rd_idx];
`else
    assign rd_cond = 1'b1;
`endif

    // Target is gated by hit so every output reads 0 out of reset.
    always_comb begin
        branch_hit_o         = valid[rd_idx] && (tag[rd_idx] == pc_IF_i[XLEN-1:IDX+2]);
        branch_decision_o    = branch_hit_o && (!rd_cond || cnt[rd_idx][1]);
        branch_target_addr_o = branch_hit_o ? target[rd_idx] : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fd <= '0;
            de <= '0;
        end else if (!stall_pipe_i) begin
            if (flush2fet_i)
                fd <= '0;
            else if (!stall_fd_i)
                fd <= '{hit: branch_hit_o, decision: branch_decision_o,
                        is_cond: rd_cond, target: branch_target_addr_o};
            if (flush2dec_i)
                de <= '0;
            else
                de <= fd;
        end
    end

    assign cond_branch_hit_EXE_o = de.hit && de.is_cond && is_cond_branch_EXE_i;
    assign cond_branch_misprediction_o = cond_branch_hit_EXE_o &&
        ((de.decision != branch_taken_i) ||
         (de.decision && (de.target != branch_target_addr_EXE_i)));
`ifdef BPU_JAL_ALLOC_EN
    assign uncond_branch_hit_EXE_o = de.hit && !de.is_cond && is_jal_EXE_i &&
                                     (de.target == branch_target_addr_EXE_i);
`else
    assign uncond_branch_hit_EXE_o = 1'b0;
`endif

    // A conditional "hit" is the one carried down the shadow pipe, not a re-lookup.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid  <= '0;
            tag    <= '0;
            target <= '0;
            cnt    <= {ENTRY_NUM{2'b01}};
`ifdef BPU_JAL_ALLOC_EN
            is_cond <= '0;
`endif
        end else if (!stall_pipe_i) begin
            if (is_cond_branch_EXE_i) begin
                if (cond_branch_hit_EXE_o) begin
                    if (branch_taken_i) begin
                        target[wr_idx] <= branch_target_addr_EXE_i;
                        if (cnt[wr_idx] != 2'b11)
                            cnt[wr_idx] <= cnt[wr_idx] + 2'b01;
                    end else if (cnt[wr_idx] != 2'b00) begin
                        cnt[wr_idx] <= cnt[wr_idx] - 2'b01;
                    end
                end else if (branch_taken_i) begin
                    valid[wr_idx]  <= 1'b1;
                    tag[wr_idx]    <= wr_tag;
                    target[wr_idx] <= branch_target_addr_EXE_i;
                    cnt[wr_idx]    <= 2'b10;
`ifdef BPU_JAL_ALLOC_EN
                    is_cond[wr_idx] <= 1'b1;
`endif
                end
            end
`ifdef BPU_JAL_ALLOC_EN
            else if (is_jal_EXE_i) begin
                valid[wr_idx]   <= 1'b1;
                tag[wr_idx]     <= wr_tag;
                target[wr_idx]  <= branch_target_addr_EXE_i;
                cnt[wr_idx]     <= 2'b11;
                is_cond[wr_idx] <= 1'b0;
            end
`endif
        end
    end
endmodule
